// File: rtl/or_reduce_pkg.sv
// Shared types and elaboration helpers for the pipelined OR-reduction tree.
// Tree level count and per-level widths are derived here from WIDTH and FANIN.
package or_reduce_pkg;

  localparam int MAX_WIDTH  = 256;
  localparam int MAX_LEVELS = 8;

  typedef struct packed {
    logic valid;
    logic inv;
  } sb_t;

  function automatic int clog_base(input int n, input int base);
    int v;
    int l;
    v = 1;
    l = 0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (v < n) begin
        v = v * base;
        l = l + 1;
      end
    end
    return l;
  endfunction

  // width of the bit vector entering level k
  function automatic int lvl_width(input int n, input int base, input int k);
    int w;
    w = n;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (i < k) w = (w + base - 1) / base;
    end
    return w;
  endfunction

endpackage

// File: rtl/or_reduce_stage.sv
// One registered level of the reduction tree: groups of FANIN bits are
// OR-ed (or XOR-ed when XOR_EN=1), with missing inputs tied to 0.
module or_reduce_stage
  import or_reduce_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FANIN  = 4,
  parameter bit XOR_EN = 1'b0,
  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  in_d,
  output logic [OUT_W-1:0] out_q
);

  logic [OUT_W*FANIN-1:0] pad;
  logic [OUT_W-1:0]       red_d;
  logic [OUT_W-1:0]       red_q;

  always_comb begin
    pad = '0;
    pad[IN_W-1:0] = in_d;
    red_d = red_q;
    if (en) begin
      for (int g = 0; g < OUT_W; g++) begin
        red_d[g] = XOR_EN ? ^pad[g*FANIN +: FANIN]
                          : |pad[g*FANIN +: FANIN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) red_q <= '0;
    else        red_q <= red_d;
  end

  assign out_q = red_q;

endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined WIDTH->1 OR reduction with NOR select and sticky accumulator.
// Define OR_REDUCE_PARITY_EN to add the out_par XOR-reduction output.
module or_reduce_pipe
  import or_reduce_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FANIN = 4,
  localparam int LEVELS = clog_base(WIDTH, FANIN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_acc
`ifdef OR_REDUCE_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic en;
  logic raw;
  logic hs;
  logic acc_d;
  logic acc_q;
  sb_t  sb_d [LEVELS];
  sb_t  sb_q [LEVELS];

  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign out_valid = sb_q[LEVELS-1].valid;
  assign hs        = out_valid & out_ready;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int IW = lvl_width(WIDTH, FANIN, k);
    localparam int OW = lvl_width(WIDTH, FANIN, k + 1);
    logic [IW-1:0] d_in;
    logic [OW-1:0] q;
`ifdef OR_REDUCE_PARITY_EN
    logic [IW-1:0] p_in;
    logic [OW-1:0] p_q;
`endif
    if (k == 0) begin : g_first
      assign d_in = in_data;
`ifdef OR_REDUCE_PARITY_EN
      assign p_in = in_data;
`endif
    end else begin : g_next
      assign d_in = g_lvl[k-1].q;
`ifdef OR_REDUCE_PARITY_EN
      assign p_in = g_lvl[k-1].p_q;
`endif
    end

    or_reduce_stage #(
      .IN_W  (IW),
      .FANIN (FANIN),
      .XOR_EN(1'b0)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .in_d (d_in),
      .out_q(q)
    );

`ifdef OR_REDUCE_PARITY_EN
    or_reduce_stage #(
      .IN_W  (IW),
      .FANIN (FANIN),
      .XOR_EN(1'b1)
    ) u_par (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .in_d (p_in),
      .out_q(p_q)
    );
`endif
  end

  assign raw   = g_lvl[LEVELS-1].q[0];
  assign out_y = raw ^ sb_q[LEVELS-1].inv;
`ifdef OR_REDUCE_PARITY_EN
  assign out_par = g_lvl[LEVELS-1].p_q[0];
`endif

  always_comb begin
    sb_d = sb_q;
    if (en) begin
      sb_d[0] = '{valid: in_valid, inv: in_inv};
      for (int k = 1; k < LEVELS; k++) sb_d[k] = sb_q[k-1];
    end
  end

  // clear first, then fold in the delivered beat's raw result
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) acc_d = 1'b0;
    if (hs && acc_en) acc_d = acc_d | raw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LEVELS; k++) sb_q[k] <= '0;
      acc_q <= 1'b0;
    end else begin
      sb_q  <= sb_d;
      acc_q <= acc_d;
    end
  end

  assign out_acc = acc_q;

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Self-checking bench for or_reduce_pipe (16/4 main instance, 10/4 odd).
// Scoreboard queue holds expected beats; a monitor pops them on delivery.
module tb_or_reduce_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_inv;
  logic        out_valid;
  logic        out_ready;
  logic        out_y;
  logic        acc_en;
  logic        acc_clr;
  logic        out_acc;
  logic        out_par;

  logic        o_in_valid;
  logic        o_in_ready;
  logic [9:0]  o_in_data;
  logic        o_out_valid;
  logic        o_out_y;
  logic        o_out_acc;
  logic        o_out_par;

  typedef struct {
    logic y;
    logic raw;
    logic par;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  int   cyc;
  int   n_out;
  bit   strict;
  logic acc_m;

  or_reduce_pipe #(.WIDTH(16), .FANIN(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_inv   (in_inv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
    .out_acc  (out_acc)
`ifdef OR_REDUCE_PARITY_EN
    ,
    .out_par  (out_par)
`endif
  );

  or_reduce_pipe #(.WIDTH(10), .FANIN(4)) u_odd (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (o_in_valid),
    .in_ready (o_in_ready),
    .in_data  (o_in_data),
    .in_inv   (1'b0),
    .out_valid(o_out_valid),
    .out_ready(1'b1),
    .out_y    (o_out_y),
    .acc_en   (1'b0),
    .acc_clr  (1'b0),
    .out_acc  (o_out_acc)
`ifdef OR_REDUCE_PARITY_EN
    ,
    .out_par  (o_out_par)
`endif
  );

`ifndef OR_REDUCE_PARITY_EN
  assign out_par   = 1'b0;
  assign o_out_par = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic monitor();
    exp_t e;
    logic hs;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        acc_m = 1'b0;
        continue;
      end
      hs = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: out_valid=1 with no beat expected");
        end else if (out_ready) begin
          e = q.pop_front();
          hs = 1'b1;
          n_out++;
          checks++;
          if (out_y !== e.y) begin
            errors++;
            $display("FAIL out_y: got %b expected %b", out_y, e.y);
          end
          if (strict) begin
            checks++;
            if (cyc - e.cyc !== 2) begin
              errors++;
              $display("FAIL latency: got %0d expected 2", cyc - e.cyc);
            end
          end
`ifdef OR_REDUCE_PARITY_EN
          checks++;
          if (out_par !== e.par) begin
            errors++;
            $display("FAIL out_par: got %b expected %b", out_par, e.par);
          end
`endif
        end
      end
      checks++;
      if (out_acc !== acc_m) begin
        errors++;
        $display("FAIL out_acc_model: got %b expected %b", out_acc, acc_m);
      end
      if (acc_clr) acc_m = 1'b0;
      if (hs && acc_en) acc_m = acc_m | e.raw;
      if (in_valid && in_ready) begin
        e.raw = |in_data;
        e.y   = (|in_data) ^ in_inv;
        e.par = ^in_data;
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic inv);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    in_inv   = inv;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats left, expected 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0001;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    o_in_valid = 1'b0;
    o_in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_y !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_y: got %b expected 0", out_y);
    end
    checks++;
    if (out_acc !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_acc: got %b expected 0", out_acc);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %b expected 1", in_ready);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_lat0: got %b expected 0", out_valid);
    end
    drive(1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_lat1: got %b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_lat2: got %b expected 1", out_valid);
    end
    drain("reset");
  endtask

  task automatic test_streaming();
    int n0;
    logic [15:0] pat [4];
    pat[0] = 16'h0000;
    pat[1] = 16'h8000;
    pat[2] = 16'h0001;
    pat[3] = 16'h0000;
    n0 = n_out;
    for (int i = 0; i < 4; i++) drive(1'b1, pat[i], 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    drain("stream");
    checks++;
    if (n_out - n0 !== 4) begin
      errors++;
      $display("FAIL stream_count: got %0d expected 4", n_out - n0);
    end
  endtask

  task automatic test_nor();
    drive(1'b1, 16'h0000, 1'b1);
    acc_en  = 1'b1;
    acc_clr = 1'b1;
    drive(1'b1, 16'h0400, 1'b1);
    acc_clr = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_acc !== 1'b0) begin
      errors++;
      $display("FAIL nor_acc0: got %b expected 0", out_acc);
    end
    @(negedge clk);
    checks++;
    if (out_acc !== 1'b1) begin
      errors++;
      $display("FAIL nor_acc1: got %b expected 1", out_acc);
    end
    drain("nor");
  endtask

  task automatic test_backpressure();
    int n0;
    n0 = n_out;
    drive(1'b1, 16'h0100, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 16'h0000, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    strict = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: rdy=%b vld=%b y=%b expected 0 1 1",
                 in_ready, out_valid, out_y);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("bp");
    strict = 1'b1;
    checks++;
    if (n_out - n0 !== 2) begin
      errors++;
      $display("FAIL bp_count: got %0d expected 2", n_out - n0);
    end
  endtask

  task automatic test_accumulate();
    @(posedge clk);
    #1;
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    drive(1'b1, 16'h0000, 1'b0);
    drive(1'b1, 16'h0010, 1'b0);
    drive(1'b1, 16'h0000, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    checks++;
    if (out_acc !== 1'b0) begin
      errors++;
      $display("FAIL acc_first: got %b expected 0", out_acc);
    end
    @(posedge clk);
    #1;
    acc_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (out_acc !== 1'b1) begin
      errors++;
      $display("FAIL acc_second: got %b expected 1", out_acc);
    end
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (out_acc !== 1'b0) begin
      errors++;
      $display("FAIL acc_clr_hs: got %b expected 0", out_acc);
    end
    acc_en = 1'b0;
    drive(1'b1, 16'h0002, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    drain("acc");
    checks++;
    if (out_acc !== 1'b0) begin
      errors++;
      $display("FAIL acc_hold: got %b expected 0", out_acc);
    end
  endtask

  task automatic odd_beat(input logic [9:0] d, input logic ey,
                          input logic ep);
    @(posedge clk);
    #1;
    o_in_valid = 1'b1;
    o_in_data  = d;
    @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL odd_ready: got %b expected 1", o_in_ready);
    end
    @(posedge clk);
    #1;
    o_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL odd_lat1: got %b expected 0", o_out_valid);
    end
    @(negedge clk);
    checks++;
    if (o_out_valid !== 1'b1 || o_out_y !== ey) begin
      errors++;
      $display("FAIL odd_y: vld=%b y=%b expected 1 %b",
               o_out_valid, o_out_y, ey);
    end
`ifdef OR_REDUCE_PARITY_EN
    checks++;
    if (o_out_par !== ep) begin
      errors++;
      $display("FAIL odd_par: got %b expected %b", o_out_par, ep);
    end
`else
    if (ep === 1'bz) $display("unused %b", o_out_par);
`endif
    checks++;
    if (o_out_acc !== 1'b0) begin
      errors++;
      $display("FAIL odd_acc: got %b expected 0", o_out_acc);
    end
  endtask

  task automatic test_odd_width();
    logic [9:0] v;
    v = 10'h200;
    odd_beat(v, |v, ^v);
    v = 10'h000;
    odd_beat(v, |v, ^v);
    v = 10'h3FF;
    odd_beat(v, |v, ^v);
    v = 10'h100;
    odd_beat(v, |v, ^v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    n_out  = 0;
    strict = 1'b1;
    acc_m  = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_streaming();
    test_nor();
    test_backpressure();
    test_accumulate();
    test_odd_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
